// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control block: stall vectors,
// exception codes, trap vector addresses and the control FSM states.
package pipe_pkg;

  // Stall vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_INVALID = 32'ha;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_ERET    = 32'he;

  localparam logic [31:0] VEC_INT = 32'h20;
  localparam logic [31:0] VEC_GEN = 32'h40;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/exc_vector.sv
// Combinational exception-code to redirect-PC mapping; eret returns to EPC,
// interrupts go to the interrupt vector, everything else to the general vector.
module exc_vector
  import pipe_pkg::*;
(
  input  logic [31:0] except_type,
  input  logic [31:0] cp0_epc,
  output logic [31:0] new_pc
);

  always_comb begin
    new_pc = VEC_GEN;
    case (except_type)
      EXC_INT:                                     new_pc = VEC_INT;
      EXC_SYSCALL, EXC_INVALID, EXC_OV, EXC_TRAP:  new_pc = VEC_GEN;
      EXC_ERET:                                    new_pc = cp0_epc;
      default:                                     new_pc = VEC_GEN;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall priority encoding, exception flush/redirect with a
// one-cycle recovery state, a sticky stall watchdog and two perf counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             except_valid,
  input  logic [31:0]      except_type,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             state_dbg
);

  pipe_state_e state, state_next;
  logic [31:0] exc_pc;
  logic [15:0] wd_cnt, wd_next;

  exc_vector u_exc_vector (
    .except_type (except_type),
    .cp0_epc     (cp0_epc),
    .new_pc      (exc_pc)
  );

  assign state_dbg = (state == ST_RECOVER);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Outputs are forced quiet during reset so no stage freezes or flushes then.
  always_comb begin
    stall      = STALL_NONE;
    flush      = 1'b0;
    new_pc     = 32'h0;
    state_next = state;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (except_valid) begin
            flush      = 1'b1;
            new_pc     = exc_pc;
            state_next = ST_RECOVER;
          end else if (stallreq_mem) begin
            stall = STALL_MEM;
          end else if (stallreq_ex) begin
            stall = STALL_EX;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end else if (stallreq_if) begin
            stall = STALL_IF;
          end
        end
        ST_RECOVER: state_next = ST_RUN;
        default:    state_next = ST_RUN;
      endcase
    end
  end

  // Watchdog counts consecutive stalled cycles and saturates at all-ones.
  always_comb begin
    wd_next = 16'd0;
    if (stall != STALL_NONE)
      wd_next = (wd_cnt == 16'hffff) ? wd_cnt : wd_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt        <= 16'd0;
      stall_timeout <= 1'b0;
      stall_cycles  <= '0;
      flush_count   <= '0;
    end else begin
      wd_cnt <= wd_next;
      if (wd_next == 16'(STALL_TIMEOUT)) stall_timeout <= 1'b1;
      if (stall[0]) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush)    flush_count  <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors with literal expectations plus a
// rule-level reference model compared against the DUT on every cycle.
module tb_pipe_ctrl;

  localparam int N     = 4;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic             except_valid;
  logic [31:0]      except_type, cp0_epc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic             state_dbg;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.STALL_TIMEOUT(N), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .except_valid  (except_valid),
    .except_type   (except_type),
    .cp0_epc       (cp0_epc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: rules stated in terms of requests and previous flush
  bit          m_prev_flush = 1'b0;
  int unsigned m_run        = 0;
  bit          m_to         = 1'b0;
  int unsigned m_stall_cyc  = 0;
  int unsigned m_flush_cnt  = 0;

  function automatic logic [31:0] vec_of(input logic [31:0] t, input logic [31:0] epc);
    if (t == 32'h1) return 32'h20;
    if (t == 32'he) return epc;
    return 32'h40;
  endfunction

  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    // registered outputs reflect every edge applied to the model so far
    check("mdl_timeout", {31'b0, stall_timeout}, {31'b0, m_to});
    check("mdl_stall_cycles", stall_cycles, m_stall_cyc);
    check("mdl_flush_count", flush_count, m_flush_cnt);
    check("mdl_recover", {31'b0, state_dbg}, {31'b0, m_prev_flush});
    e_stall = 6'b0;
    e_flush = 1'b0;
    e_pc    = 32'h0;
    if (!rst && !m_prev_flush) begin
      if (except_valid) begin
        e_flush = 1'b1;
        e_pc    = vec_of(except_type, cp0_epc);
      end else if (stallreq_mem) e_stall = 6'b011111;
      else if (stallreq_ex)      e_stall = 6'b001111;
      else if (stallreq_id)      e_stall = 6'b000111;
      else if (stallreq_if)      e_stall = 6'b000011;
    end
    check("mdl_stall", {26'b0, stall}, {26'b0, e_stall});
    check("mdl_flush", {31'b0, flush}, {31'b0, e_flush});
    check("mdl_new_pc", new_pc, e_pc);
    if (rst) begin
      m_prev_flush = 1'b0;
      m_run        = 0;
      m_to         = 1'b0;
      m_stall_cyc  = 0;
      m_flush_cnt  = 0;
    end else begin
      if (e_stall != 6'b0) begin
        if (m_run < 65535) m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run == N) m_to = 1'b1;
      if (e_stall[0]) m_stall_cyc++;
      if (e_flush) m_flush_cnt++;
      m_prev_flush = e_flush;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic f, input logic d, input logic e, input logic m);
    stallreq_if  = f;
    stallreq_id  = d;
    stallreq_ex  = e;
    stallreq_mem = m;
  endtask

  task automatic set_exc(input logic v, input logic [31:0] t);
    except_valid = v;
    except_type  = t;
  endtask

  typedef struct {
    logic        ev;
    logic [31:0] et;
    logic [3:0]  req;  // {mem, ex, id, if}
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst = 1'b1;
    set_req(0, 0, 0, 0);
    set_exc(0, 32'h0);
    cp0_epc = 32'h0;
    vecs[0] = '{1'b0, 32'h0, 4'b0001};
    vecs[1] = '{1'b0, 32'h0, 4'b0011};
    vecs[2] = '{1'b1, 32'h5, 4'b1111};
    vecs[3] = '{1'b1, 32'ha, 4'b0000};
    vecs[4] = '{1'b0, 32'h0, 4'b0101};
    vecs[5] = '{1'b1, 32'hc, 4'b0010};
    vecs[6] = '{1'b0, 32'h0, 4'b0000};
    vecs[7] = '{1'b1, 32'hd, 4'b1000};
    vecs[8] = '{1'b1, 32'h1, 4'b0000};
    vecs[9] = '{1'b0, 32'h0, 4'b1000};
    step();
    step();

    // reset forces quiet outputs even with a request present
    set_req(0, 0, 1, 0);
    @(negedge clk);
    check("rst_stall", {26'b0, stall}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_cnt", stall_cycles, 32'h0);
    check("rst_to", {31'b0, stall_timeout}, 32'h0);
    step();
    rst = 1'b0;
    set_req(0, 0, 0, 0);
    step();

    // priority
    set_req(0, 1, 0, 0);
    @(negedge clk);
    check("prio_id", {26'b0, stall}, 32'h07);
    check("prio_cnt0", stall_cycles, 32'h0);
    step();
    set_req(0, 1, 0, 1);
    @(negedge clk);
    check("prio_mem", {26'b0, stall}, 32'h1f);
    step();
    set_req(0, 0, 0, 0);
    @(negedge clk);
    check("prio_none", {26'b0, stall}, 32'h0);
    check("prio_cnt2", stall_cycles, 32'h2);
    step();

    // exception redirect
    set_exc(1, 32'h8);
    @(negedge clk);
    check("exc_flush", {31'b0, flush}, 32'h1);
    check("exc_pc", new_pc, 32'h40);
    check("exc_stall", {26'b0, stall}, 32'h0);
    step();
    set_exc(0, 32'h0);
    @(negedge clk);
    check("exc_flush_off", {31'b0, flush}, 32'h0);
    check("exc_fcnt", flush_count, 32'h1);
    step();

    // eret
    cp0_epc = 32'h0000_1234;
    set_exc(1, 32'he);
    @(negedge clk);
    check("eret_pc", new_pc, 32'h0000_1234);
    check("eret_flush", {31'b0, flush}, 32'h1);
    step();
    set_exc(0, 32'h0);
    step();

    // recovery masking: exception held two cycles with an EX stall
    set_exc(1, 32'h1);
    set_req(0, 0, 1, 0);
    @(negedge clk);
    check("rec_c1_flush", {31'b0, flush}, 32'h1);
    check("rec_c1_stall", {26'b0, stall}, 32'h0);
    check("rec_c1_pc", new_pc, 32'h20);
    step();
    @(negedge clk);
    check("rec_c2_flush", {31'b0, flush}, 32'h0);
    check("rec_c2_stall", {26'b0, stall}, 32'h0);
    step();
    set_exc(0, 32'h0);
    @(negedge clk);
    check("rec_c3_stall", {26'b0, stall}, 32'h0f);
    check("rec_fcnt", flush_count, 32'h3);
    step();
    set_req(0, 0, 0, 0);
    step();

    // watchdog: EX stall held N cycles
    set_req(0, 0, 1, 0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("wd_before", {31'b0, stall_timeout}, 32'h0);
      step();
    end
    set_req(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wd_sticky", {31'b0, stall_timeout}, 32'h1);
      step();
    end

    // reset mid-stall
    set_req(0, 1, 0, 0);
    @(negedge clk);
    check("mid_stall", {26'b0, stall}, 32'h07);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_stall", {26'b0, stall}, 32'h0);
    step();
    rst = 1'b0;
    set_req(0, 0, 0, 0);
    @(negedge clk);
    check("mid_to", {31'b0, stall_timeout}, 32'h0);
    check("mid_scnt", stall_cycles, 32'h0);
    check("mid_fcnt", flush_count, 32'h0);
    check("mid_state", {31'b0, state_dbg}, 32'h0);
    step();

    // reset while in recovery
    set_exc(1, 32'ha);
    step();
    set_exc(0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("recrst_state_in", {31'b0, state_dbg}, 32'h1);
    step();
    rst = 1'b0;
    set_exc(1, 32'h5);
    @(negedge clk);
    check("recrst_state", {31'b0, state_dbg}, 32'h0);
    check("recrst_fcnt", flush_count, 32'h0);
    check("recrst_flush", {31'b0, flush}, 32'h1);
    check("recrst_pc", new_pc, 32'h40);
    step();
    set_exc(0, 32'h0);
    step();

    // directed vector table, checked by the model
    for (int i = 0; i < 10; i++) begin
      set_exc(vecs[i].ev, vecs[i].et);
      set_req(vecs[i].req[0], vecs[i].req[1], vecs[i].req[2], vecs[i].req[3]);
      step();
    end
    set_exc(0, 32'h0);
    set_req(0, 0, 0, 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control block for the five-stage core. It turns stall requests from the IF/ID/EX/MEM stages into the per-stage stall vector that freezes PC and the pipeline registers, including MEM/WB and its HI/LO write path. It turns a MEM-stage exception into a one-cycle flush with a redirect PC, then runs a one-cycle recovery state. It also keeps a stall watchdog and two performance counters.

## Interface
- STALL_TIMEOUT, default 1023: number of consecutive stalled cycles at which stall_timeout sets; valid range 1..65535.
- CNT_W, default 32: width of the performance counters.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_if  in  1  IF stage requests a stall
- stallreq_id  in  1  ID stage requests a stall
- stallreq_ex  in  1  EX stage requests a stall (multi-cycle mul/div)
- stallreq_mem  in  1  MEM stage requests a stall
- except_valid  in  1  MEM stage reports an exception this cycle
- except_type  in  32  exception code, valid when except_valid=1
- cp0_epc  in  32  current EPC from CP0
- stall  out  6  per-stage stall: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  redirect target, valid when flush=1, otherwise 0
- stall_timeout  out  1  sticky watchdog flag
- stall_cycles  out  CNT_W  count of cycles with stall[0]=1
- flush_count  out  CNT_W  count of flush cycles

## Operation
- FSM states: RUN and RECOVER. Reset state is RUN.
- In RUN, outputs are combinational from the inputs. Priority, highest first:
  - except_valid: flush=1, stall=6'b000000, new_pc from the exception table. Next state is RECOVER.
  - stallreq_mem: stall=6'b011111.
  - stallreq_ex: stall=6'b001111.
  - stallreq_id: stall=6'b000111.
  - stallreq_if: stall=6'b000011.
  - No request: stall=0, flush=0, new_pc=0.
- In RECOVER:
  - stall=0 and flush=0.
  - All stall requests and except_valid are ignored. The pipeline has just been cleared, so these inputs are stale.
  - Next state is always RUN.
- Exception table:
  - 32'h1 (interrupt): new_pc = 32'h20.
  - 32'h8 (syscall), 32'ha (invalid instruction), 32'hc (overflow), 32'hd (trap): new_pc = 32'h40.
  - 32'he (eret): new_pc = cp0_epc.
  - Any other code: new_pc = 32'h40.
- Watchdog:
  - A 16-bit counter increments each cycle stall!=0 and saturates.
  - It clears to 0 on any cycle with stall==0, including flush cycles.
  - When the counter reaches STALL_TIMEOUT, stall_timeout is set and stays 1 until rst.
- Counters:
  - stall_cycles increments on every cycle with stall[0]=1.
  - flush_count increments on every cycle with flush=1.
  - Both wrap modulo 2^CNT_W.

## Timing
- stall, flush and new_pc have zero latency: they are combinational from the inputs and the registered state. Pipeline registers sample them at the same clk edge.
- State, the watchdog counter, stall_timeout and both performance counters are registered and update at the edge that ends the cycle.
- Reset values: state=RUN, watchdog=0, stall_timeout=0, stall_cycles=0, flush_count=0.
- While rst=1, stall=0, flush=0 and new_pc=0, regardless of the inputs.
- Simultaneous except_valid and any stall request in RUN: flush wins and stall=0.
- except_valid held for two cycles: only the first cycle flushes. The second cycle falls in RECOVER and is ignored.
- rst asserted in RECOVER: the next state is RUN and every counter clears.
- Watchdog timing: with STALL_TIMEOUT=N, a request held from cycle 0 sets stall_timeout visibly after the edge ending cycle N-1.

## Structure
- Shared package pipe_pkg holds:
  - Stall vector constants STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM.
  - Exception code constants EXC_INT, EXC_SYSCALL, EXC_INVALID, EXC_OV, EXC_TRAP, EXC_ERET.
  - Vector addresses VEC_INT=32'h20 and VEC_GEN=32'h40.
  - The two-value state enum.
- Sub-module exc_vector: purely combinational mapping from (except_type, cp0_epc) to new_pc. It is reused by CP0 verification.

## Test plan
- Priority: hold stallreq_id=1, then add stallreq_mem=1 in the same cycle. Expect stall=6'b000111, then 6'b011111. Drop all requests: stall=0, and stall_cycles has advanced by 2.
- Exception redirect: except_valid=1 with except_type=32'h8. Expect flush=1, new_pc=32'h40, stall=0 in that cycle. Next cycle: flush=0, and flush_count=1.
- eret: cp0_epc=32'h0000_1234, except_valid=1, except_type=32'he. Expect new_pc=32'h0000_1234 and flush=1.
- Recovery masking: except_valid held 2 cycles with stallreq_ex=1 throughout. Cycle 1: flush=1, stall=0. Cycle 2: flush=0, stall=0. Cycle 3: stall=6'b001111.
- Watchdog: STALL_TIMEOUT=4, stallreq_ex held 4 cycles. Expect stall_timeout=1 from cycle 4 on. It stays 1 after stallreq_ex drops and clears only on rst.
- Reset mid-operation: rst=1 during a stall. Expect stall=0 that cycle; state RUN and all counters 0 afterwards.
